mult_err_sweep: RTL and testbench

Exhaustive error-characterisation stage for the 4x4 approximate multipliers. It drives every one of the 256 operand pairs into the multiplier under test and consumes the 8-bit products it returns. It compares each product against the exact product and accumulates error statistics (error count, absolute-error sum, signed-error sum, maximum absolute error). The results are read after a single start pulse. It sits on both sides of the multiplier: upstream as its operand source, downstream as its product consumer.

---
 rtl/mult_err_pkg.sv | 28 ++
 rtl/mult_err_dly.sv | 43 ++++
 rtl/mult_err_sweep.sv | 154 +++++++++++++++
 tb/tb_mult_err_sweep.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_err_pkg.sv
// Shared types and sizes for the approximate-multiplier error sweep.
package mult_err_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned PROD_W    = 8;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned NUM_PAIRS = 256;
    localparam int unsigned SUM_W     = 16;
    localparam int unsigned SERR_W    = 17;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned LAT_MAX   = 4;
    localparam int unsigned DCNT_W    = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Magnitude of a 9-bit signed error; the range never reaches -256.
    function automatic logic [PROD_W-1:0] abs_err(input logic [PROD_W:0] e);
        logic [PROD_W:0] neg;
        neg = -e;
        return e[PROD_W] ? neg[PROD_W-1:0] : e[PROD_W-1:0];
    endfunction

endpackage

// File: rtl/mult_err_dly.sv
// LAT-deep register line carrying {valid, op_a, op_b} alongside the multiplier
// under test; LAT=0 is a straight pass-through.
// Ports: clk, rst_n; vld_i/a_i/b_i in; vld_o/a_o/b_o out (delayed by LAT).
module mult_err_dly
    import mult_err_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vld_i,
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    output logic            vld_o,
    output logic [OP_W-1:0] a_o,
    output logic [OP_W-1:0] b_o
);

    localparam int unsigned W = 1 + 2 * OP_W;

    if (LAT == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign vld_o = vld_i;
        assign a_o   = a_i;
        assign b_o   = b_i;
    end else begin : g_pipe
        logic [W-1:0] pipe_q [LAT];

        // Shift register; stage 0 captures the driven pair.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= {vld_i, a_i, b_i};
                for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign {vld_o, a_o, b_o} = pipe_q[LAT-1];
    end

endmodule

// File: rtl/mult_err_sweep.sv
// Exhaustive 4x4 approximate-multiplier error characterisation: drives all 256
// operand pairs, compares returned products with the exact product and
// accumulates error statistics.
// Ports: clk, rst_n, start in; op_a/op_b out to the multiplier; prod_approx in;
//        busy, done, err_count, sum_abs_err, sum_err, max_abs_err out.
module mult_err_sweep
    import mult_err_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    input  logic [PROD_W-1:0] prod_approx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [SERR_W-1:0] sum_err,
    output logic [PROD_W-1:0] max_abs_err
);

    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_PAIRS - 1);
    localparam int unsigned      DRAIN_LAST_I = (LAT > 0) ? LAT - 1 : 0;
    localparam logic [DCNT_W-1:0] DRAIN_LAST  = DCNT_W'(DRAIN_LAST_I);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    op_q, op_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0]    sabs_q, sabs_d;
    logic [SERR_W-1:0]   serr_q, serr_d;
    logic [PROD_W-1:0]   max_q, max_d;

    logic                d_vld;
    logic [OP_W-1:0]     d_a, d_b;
    logic [PROD_W-1:0]   exact;
    logic [PROD_W:0]     err;
    logic [PROD_W-1:0]   err_abs;

    // Operands travel with a valid bit so samples line up with prod_approx.
    mult_err_dly #(.LAT(LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (state_q == ST_SWEEP),
        .a_i   (op_q[IDX_W-1:OP_W]),
        .b_i   (op_q[OP_W-1:0]),
        .vld_o (d_vld),
        .a_o   (d_a),
        .b_o   (d_b)
    );

    // Next-state, index and control outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DRAIN_LAST) state_d = ST_DONE;
                else                      dcnt_d  = dcnt_q + DCNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        op_d   = (state_d == ST_SWEEP) ? idx_d : '0;
        busy_d = (state_d == ST_SWEEP) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Exact product and signed error of the current sample.
    always_comb begin
        exact   = PROD_W'(d_a) * PROD_W'(d_b);
        err     = {1'b0, prod_approx} - {1'b0, exact};
        err_abs = abs_err(err);
    end

    // Accumulators: cleared on an accepted start, updated on valid samples.
    always_comb begin
        cnt_d  = cnt_q;
        sabs_d = sabs_q;
        serr_d = serr_q;
        max_d  = max_q;
        if (clr) begin
            cnt_d  = '0;
            sabs_d = '0;
            serr_d = '0;
            max_d  = '0;
        end else if (d_vld) begin
            cnt_d  = cnt_q + CNT_W'(err != '0);
            sabs_d = sabs_q + SUM_W'(err_abs);
            serr_d = serr_q + {{(SERR_W-PROD_W-1){err[PROD_W]}}, err};
            if (err_abs > max_q) max_d = err_abs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sabs_q  <= '0;
            serr_q  <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sabs_q  <= sabs_d;
            serr_q  <= serr_d;
            max_q   <= max_d;
        end
    end

    assign op_a        = op_q[IDX_W-1:OP_W];
    assign op_b        = op_q[OP_W-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = cnt_q;
    assign sum_abs_err = sabs_q;
    assign sum_err     = serr_q;
    assign max_abs_err = max_q;

endmodule

// File: tb/tb_mult_err_sweep.sv
// Bench for mult_err_sweep: three instances (LAT=0,1,3) each with its own
// behavioural multiplier model of matching latency.
module tb_mult_err_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [2:0]      start_v;
    logic [1:0]      mode0, mode1, mode3;
    logic [2:0][3:0] opa, opb;
    logic [7:0]      p0, p1, p3a, p3b, p3;
    logic [2:0]      busy_v, done_v;
    logic [2:0][8:0]  ec_v;
    logic [2:0][15:0] sa_v;
    logic [2:0][16:0] se_v;
    logic [2:0][7:0]  mx_v;

    int checks   = 0;
    int failures = 0;
    int sel      = 1;

    // Multiplier models: 0 exact, 1 LSB forced to 0, 2 constant 8'hFF.
    function automatic logic [7:0] model(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ex;
        ex = 8'(a) * 8'(b);
        case (m)
            2'd0:    return ex;
            2'd1:    return ex & 8'hFE;
            default: return 8'hFF;
        endcase
    endfunction

    assign p0 = model(mode0, opa[0], opb[0]);
    always @(posedge clk) p1 <= model(mode1, opa[1], opb[1]);
    always @(posedge clk) begin
        p3a <= model(mode3, opa[2], opb[2]);
        p3b <= p3a;
        p3  <= p3b;
    end

    mult_err_sweep #(.LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_a(opa[0]), .op_b(opb[0]),
        .prod_approx(p0), .busy(busy_v[0]), .done(done_v[0]), .err_count(ec_v[0]),
        .sum_abs_err(sa_v[0]), .sum_err(se_v[0]), .max_abs_err(mx_v[0]));
    mult_err_sweep #(.LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_a(opa[1]), .op_b(opb[1]),
        .prod_approx(p1), .busy(busy_v[1]), .done(done_v[1]), .err_count(ec_v[1]),
        .sum_abs_err(sa_v[1]), .sum_err(se_v[1]), .max_abs_err(mx_v[1]));
    mult_err_sweep #(.LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op_a(opa[2]), .op_b(opb[2]),
        .prod_approx(p3), .busy(busy_v[2]), .done(done_v[2]), .err_count(ec_v[2]),
        .sum_abs_err(sa_v[2]), .sum_err(se_v[2]), .max_abs_err(mx_v[2]));

    // Selected-instance view.
    logic [7:0]  s_op;
    logic        s_busy, s_done;
    logic [8:0]  s_ec;
    logic [15:0] s_sa;
    logic [16:0] s_se;
    logic [7:0]  s_mx;
    always_comb begin
        s_op   = {opa[sel], opb[sel]};
        s_busy = busy_v[sel];
        s_done = done_v[sel];
        s_ec   = ec_v[sel];
        s_sa   = sa_v[sel];
        s_se   = se_v[sel];
        s_mx   = mx_v[sel];
    end

    // One full sweep on instance s with latency lat; optional start re-pulse.
    task automatic do_sweep(input int s, input int lat, input string nm,
                            input logic [8:0] ec, input logic [15:0] sa,
                            input logic [16:0] se, input logic [7:0] mx,
                            input int repulse);
        int bad_op = 0, bad_ctl = 0, first_op = -1, first_ctl = -1;
        logic [7:0] exp_op;
        logic exp_busy, exp_done;
        sel = s;
        @(negedge clk);
        start_v[s] = 1'b1;
        for (int c = 1; c <= 257 + lat; c++) begin
            @(negedge clk);
            start_v[s] = (c == repulse);
            exp_op   = (c <= 256) ? 8'(c - 1) : 8'd0;
            exp_busy = (c < 257 + lat);
            exp_done = (c == 257 + lat);
            if (s_op !== exp_op) begin bad_op++; if (first_op < 0) first_op = c; end
            if (s_busy !== exp_busy || s_done !== exp_done) begin
                bad_ctl++; if (first_ctl < 0) first_ctl = c;
            end
            if (c == 1) begin
                checks++;
                if (s_op !== 8'h00 || s_done !== 1'b0 || s_ec !== 9'd0 || s_se !== 17'd0) begin
                    failures++;
                    $display("FAIL %s cycle1 op=%h done=%b ec=%0d se=%h need op=00 done=0 ec=0 se=0",
                             nm, s_op, s_done, s_ec, s_se);
                end
            end
            if (c == 16) begin
                checks++;
                if (s_op !== 8'h0F) begin
                    failures++; $display("FAIL %s cycle16 op=%h need 0f", nm, s_op);
                end
            end
            if (c == 256) begin
                checks++;
                if (s_op !== 8'hFF) begin
                    failures++; $display("FAIL %s cycle256 op=%h need ff", nm, s_op);
                end
            end
        end
        start_v[s] = 1'b0;
        checks++;
        if (bad_op != 0) begin
            failures++; $display("FAIL %s op_seq bad=%0d first_cycle=%0d need 0 bad", nm, bad_op, first_op);
        end
        checks++;
        if (bad_ctl != 0) begin
            failures++; $display("FAIL %s busy_done_seq bad=%0d first_cycle=%0d done_cycle_need=%0d",
                                 nm, bad_ctl, first_ctl, 257 + lat);
        end
        checks++;
        if (s_ec !== ec) begin failures++; $display("FAIL %s err_count got=%0d need=%0d", nm, s_ec, ec); end
        checks++;
        if (s_sa !== sa) begin failures++; $display("FAIL %s sum_abs_err got=%0d need=%0d", nm, s_sa, sa); end
        checks++;
        if (s_se !== se) begin failures++; $display("FAIL %s sum_err got=%h need=%h", nm, s_se, se); end
        checks++;
        if (s_mx !== mx) begin failures++; $display("FAIL %s max_abs_err got=%0d need=%0d", nm, s_mx, mx); end
        repeat (3) @(negedge clk);
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_op !== 8'h00 || s_ec !== ec || s_sa !== sa) begin
            failures++;
            $display("FAIL %s done_hold done=%b busy=%b op=%h ec=%0d sa=%0d need 1 0 00 %0d %0d",
                     nm, s_done, s_busy, s_op, s_ec, s_sa, ec, sa);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start_v = '0; mode0 = 2'd0; mode1 = 2'd0; mode3 = 2'd0;
        #3 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({opa[s], opb[s]} !== 8'h00 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 ||
                ec_v[s] !== 9'd0 || sa_v[s] !== 16'd0 || se_v[s] !== 17'd0 || mx_v[s] !== 8'd0) begin
                failures++;
                $display("FAIL reset inst%0d op=%h busy=%b done=%b ec=%0d sa=%0d se=%h mx=%0d need all 0",
                         s, {opa[s], opb[s]}, busy_v[s], done_v[s], ec_v[s], sa_v[s], se_v[s], mx_v[s]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exact_lat1();
        mode1 = 2'd0;
        do_sweep(1, 1, "exact_lat1", 9'd0, 16'd0, 17'd0, 8'd0, 0);
    endtask

    task automatic test_lsb_drop_lat1();
        mode1 = 2'd1;
        do_sweep(1, 1, "lsb_lat1", 9'd64, 16'd64, 17'h1FFC0, 8'd1, 0);
    endtask

    task automatic test_restart_clears();
        mode1 = 2'd0;
        do_sweep(1, 1, "restart_lat1", 9'd0, 16'd0, 17'd0, 8'd0, 0);
    endtask

    task automatic test_const_ff_lat0();
        mode0 = 2'd2;
        do_sweep(0, 0, "ff_lat0", 9'd256, 16'd50880, 17'd50880, 8'd255, 0);
    endtask

    task automatic test_back_to_back_lat3();
        mode3 = 2'd0;
        do_sweep(2, 3, "repulse_lat3", 9'd0, 16'd0, 17'd0, 8'd0, 50);
        do_sweep(2, 3, "again_lat3", 9'd0, 16'd0, 17'd0, 8'd0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        mode1 = 2'd1;
        sel = 1;
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
        end
        checks++;
        if (s_busy !== 1'b1 || s_ec !== 9'd24 || s_se !== 17'h1FFE8) begin
            failures++;
            $display("FAIL midsweep_c100 busy=%b ec=%0d se=%h need 1 24 1ffe8", s_busy, s_ec, s_se);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_op !== 8'h00 || s_ec !== 9'd0 ||
            s_sa !== 16'd0 || s_se !== 17'd0 || s_mx !== 8'd0) begin
            failures++;
            $display("FAIL midsweep_reset busy=%b done=%b op=%h ec=%0d sa=%0d se=%h mx=%0d need all 0",
                     s_busy, s_done, s_op, s_ec, s_sa, s_se, s_mx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_op !== 8'h00 || s_ec !== 9'd0) begin
            failures++;
            $display("FAIL post_reset_idle busy=%b done=%b op=%h ec=%0d need 0 0 00 0",
                     s_busy, s_done, s_op, s_ec);
        end
        do_sweep(1, 1, "after_reset_lat1", 9'd64, 16'd64, 17'h1FFC0, 8'd1, 0);
    endtask

    initial begin
        test_reset();
        test_exact_lat1();
        test_lsb_drop_lat1();
        test_restart_clears();
        test_const_ff_lat0();
        test_back_to_back_lat3();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
